// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters: registered priority pointer plus an IDLE/BUSY FSM.
// Optional macro GRANT_TIMEOUT_EN adds a forced release after HOLD_MAX busy cycles.
module rr_arbiter8 #(
  parameter int unsigned PRIO_INIT = 0,
  parameter int unsigned HOLD_MAX  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_vld,
  output logic       timeout
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] gnt_q, gnt_d;
  logic       vld_q, vld_d;
  logic       to_q, to_d;
  logic [3:0] pick;

`ifdef GRANT_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
  logic [7:0] cnt_q, cnt_d;
`endif

  // Returns {found, index}: first set bit scanning p, p+1, ... with 3-bit wrap.
  function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic [2:0] c;
    logic [3:0] res;
    res = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      c = p + 3'(i);
      if (!res[3] && r[c]) res = {1'b1, c};
    end
    return res;
  endfunction

  assign pick = rr_pick(req, ptr_q);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    gnt_d   = gnt_q;
    vld_d   = vld_q;
    to_d    = 1'b0;
`ifdef GRANT_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick[3]) begin
          idx_d   = pick[2:0];
          gnt_d   = 8'(1) << pick[2:0];
          vld_d   = 1'b1;
          state_d = BUSY;
`ifdef GRANT_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      BUSY: begin
        // An owner dropping req on the timeout edge is a normal release, so it is checked first.
        if (!req[idx_q]) begin
          gnt_d   = '0;
          vld_d   = 1'b0;
          ptr_d   = idx_q + 3'd1;
          state_d = IDLE;
        end
`ifdef GRANT_TIMEOUT_EN
        else if (cnt_q == HOLD_LAST) begin
          gnt_d   = '0;
          vld_d   = 1'b0;
          ptr_d   = idx_q + 3'd1;
          to_d    = 1'b1;
          state_d = IDLE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 3'(PRIO_INIT);
      idx_q   <= '0;
      gnt_q   <= '0;
      vld_q   <= 1'b0;
      to_q    <= 1'b0;
`ifdef GRANT_TIMEOUT_EN
      cnt_q   <= '0;
`endif
      assert (PRIO_INIT <= 7 && HOLD_MAX >= 1 && HOLD_MAX <= 255);
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      gnt_q   <= gnt_d;
      vld_q   <= vld_d;
      to_q    <= to_d;
`ifdef GRANT_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign gnt     = gnt_q;
  assign gnt_idx = idx_q;
  assign gnt_vld = vld_q;
  assign timeout = to_q;

endmodule
